// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared widths, derived beat geometry and FSM state encoding
//                for the DMA read engine and the accelerator control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int DMA_DATA_W     = 256;
    localparam int DMA_MEM_W      = 32;
    localparam int WORDS_PER_BEAT = DMA_DATA_W / DMA_MEM_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } dma_state_e;

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_beat_packer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_beat_packer
//  Description : Gathers MEM_W-wide read words into a DATA_W beat, then moves
//                the full beat into an output register that drives a
//                valid/ready stream.
//  Ports       : clk, rst           - clock, async active-high reset
//                wr_en_i/wr_last_i  - store a word / word completes the beat
//                wr_idx_i/wr_data_i - word slot and word data
//                ready_i            - consumer accepts the presented beat
//                gather_full_o      - gather register holds a complete beat
//                move_o             - gather -> output transfer this cycle
//                accept_o           - output beat accepted this cycle
//                valid_o/data_o     - stream beat
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_beat_packer
    import dma_pkg::*;
#(
    parameter int DATA_W = DMA_DATA_W,
    parameter int MEM_W  = DMA_MEM_W,
    parameter int WIDX_W = $clog2(DMA_DATA_W / DMA_MEM_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              wr_last_i,
    input  logic [WIDX_W-1:0] wr_idx_i,
    input  logic [MEM_W-1:0]  wr_data_i,
    input  logic              ready_i,
    output logic              gather_full_o,
    output logic              move_o,
    output logic              accept_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] gather_q;
    logic              gfull_q;
    logic [DATA_W-1:0] out_q;
    logic              ofull_q;

    logic w_accept;
    logic w_move;

    assign w_accept = ofull_q & ready_i;
    // The output slot frees up in the same cycle its beat is accepted, so a
    // waiting gather can follow it without a bubble.
    assign w_move   = gfull_q & (~ofull_q | w_accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gather_q <= '0;
            gfull_q  <= 1'b0;
            out_q    <= '0;
            ofull_q  <= 1'b0;
        end else begin
            // A write only happens while the gather is not full, so it never
            // coincides with a move.
            if (wr_en_i) begin
                gather_q[wr_idx_i*MEM_W +: MEM_W] <= wr_data_i;
                if (wr_last_i) begin
                    gfull_q <= 1'b1;
                end
            end
            if (w_move) begin
                out_q   <= gather_q;
                ofull_q <= 1'b1;
                gfull_q <= 1'b0;
            end else if (w_accept) begin
                ofull_q <= 1'b0;
            end
        end
    end

    assign gather_full_o = gfull_q;
    assign move_o        = w_move;
    assign accept_o      = w_accept;
    assign valid_o       = ofull_q;
    assign data_o        = out_q;

endmodule : dma_beat_packer
`default_nettype wire

// File: rtl/dma_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dma_read_engine
//  Description : Burst read DMA. Issues single-word memory reads (one
//                outstanding), packs them into DATA_W beats and streams the
//                beats out with valid/ready.
//  Ports       : clk, rst                 - clock, async active-high reset
//                dma_start_i/addr_i/burst_len_i - burst request (len = beats-1)
//                dma_valid_o/ready_i/data_o - output beat stream
//                dma_busy_o, dma_done_o     - burst status / completion pulse
//                mem_req_o/addr_o/gnt_i     - memory read request
//                mem_rvalid_i/rdata_i       - memory read response
//                mem_rerr_i, dma_err_o      - only with DMA_READ_ENGINE_ERR_EN
//  Config      : `define DMA_READ_ENGINE_ERR_EN adds error-response handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_read_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DMA_DATA_W,
    parameter int MEM_W  = DMA_MEM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_start_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [3:0]        dma_burst_len_i,
    output logic              dma_valid_o,
    input  logic              dma_ready_i,
    output logic [DATA_W-1:0] dma_data_o,
    output logic              dma_busy_o,
    output logic              dma_done_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [MEM_W-1:0]  mem_rdata_i
`ifdef DMA_READ_ENGINE_ERR_EN
    ,
    input  logic              mem_rerr_i,
    output logic              dma_err_o
`endif
);

    localparam int                WPB          = DATA_W / MEM_W;
    localparam int                WIDX_W       = $clog2(WPB);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ADDR_W'(DATA_W/8 - 1);
    localparam logic [ADDR_W-1:0] c_WORD_BYTES = ADDR_W'(MEM_W/8);
    localparam logic [WIDX_W-1:0] c_LAST_WORD  = WIDX_W'(WPB - 1);

    dma_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        beats_left_q;
    logic [WIDX_W-1:0] word_idx_q;
    logic              mem_req_q;
    logic              busy_q;
    logic              done_q;

    logic w_gfull;
    logic w_move;
    logic w_accept;
    logic w_start_ok;
    logic w_rsp;
    logic w_rerr;
    logic w_wr;

    // A start landing in the done cycle is dropped so the completion pulse
    // and a new burst never overlap.
    assign w_start_ok = dma_start_i & (state_q == ST_IDLE) & ~done_q;
    // Responses only count while a read is actually outstanding.
    assign w_rsp      = (state_q == ST_WAIT) & ~w_gfull & mem_rvalid_i;
`ifdef DMA_READ_ENGINE_ERR_EN
    assign w_rerr     = w_rsp & mem_rerr_i;
`else
    assign w_rerr     = 1'b0;
`endif
    assign w_wr       = w_rsp & ~w_rerr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            word_idx_q   <= '0;
            mem_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        addr_q       <= dma_addr_i & ~c_ALIGN_MASK;
                        beats_left_q <= dma_burst_len_i;
                        word_idx_q   <= '0;
                        mem_req_q    <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_q <= 1'b0;
                        addr_q    <= addr_q + c_WORD_BYTES;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_gfull) begin
                        // Completed beat still parked in the gather register:
                        // next read waits until it moves out.
                        if (w_move) begin
                            mem_req_q <= 1'b1;
                            state_q   <= ST_REQ;
                        end
                    end else if (w_rerr) begin
                        word_idx_q <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else if (w_wr) begin
                        if (word_idx_q == c_LAST_WORD) begin
                            word_idx_q <= '0;
                            if (beats_left_q == 4'd0) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                beats_left_q <= beats_left_q - 4'd1;
                            end
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                            mem_req_q  <= 1'b1;
                            state_q    <= ST_REQ;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Final beat is the one accepted once the gather is empty.
                    if (!w_gfull && w_accept) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DMA_READ_ENGINE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_start_ok) begin
            err_q <= 1'b0;
        end else if (w_rerr) begin
            err_q <= 1'b1;
        end
    end

    assign dma_err_o = err_q;
`endif

    dma_beat_packer #(
        .DATA_W (DATA_W),
        .MEM_W  (MEM_W),
        .WIDX_W (WIDX_W)
    ) u_packer (
        .clk           (clk),
        .rst           (rst),
        .wr_en_i       (w_wr),
        .wr_last_i     (w_wr & (word_idx_q == c_LAST_WORD)),
        .wr_idx_i      (word_idx_q),
        .wr_data_i     (mem_rdata_i),
        .ready_i       (dma_ready_i),
        .gather_full_o (w_gfull),
        .move_o        (w_move),
        .accept_o      (w_accept),
        .valid_o       (dma_valid_o),
        .data_o        (dma_data_o)
    );

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = addr_q;
    assign dma_busy_o = busy_q;
    assign dma_done_o = done_q;

endmodule : dma_read_engine
`default_nettype wire

// File: tb/tb_dma_read_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_read_engine
//  Description : Directed bench for dma_read_engine. A memory responder grants
//                requests and returns word data; expected addresses and beats
//                are queued when each burst is launched and consumed as the
//                DUT produces them. Error scenario built with
//                DMA_READ_ENGINE_ERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_read_engine;

    localparam int DATA_W = 256;
    localparam int MEM_W  = 32;
    localparam int WPB    = DATA_W / MEM_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dma_start_i = 1'b0;
    logic [31:0]       dma_addr_i = '0;
    logic [3:0]        dma_burst_len_i = '0;
    logic              dma_valid_o;
    logic              dma_ready_i;
    logic [DATA_W-1:0] dma_data_o;
    logic              dma_busy_o;
    logic              dma_done_o;
    logic              mem_req_o;
    logic [31:0]       mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [MEM_W-1:0]  mem_rdata_i;
`ifdef DMA_READ_ENGINE_ERR_EN
    logic              mem_rerr_i;
    logic              dma_err_o;
`endif

    dma_read_engine #(.ADDR_W(32), .DATA_W(DATA_W), .MEM_W(MEM_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .dma_start_i     (dma_start_i),
        .dma_addr_i      (dma_addr_i),
        .dma_burst_len_i (dma_burst_len_i),
        .dma_valid_o     (dma_valid_o),
        .dma_ready_i     (dma_ready_i),
        .dma_data_o      (dma_data_o),
        .dma_busy_o      (dma_busy_o),
        .dma_done_o      (dma_done_o),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
`ifdef DMA_READ_ENGINE_ERR_EN
        ,
        .mem_rerr_i      (mem_rerr_i),
        .dma_err_o       (dma_err_o)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [31:0]       exp_addr_q[$];
    logic [DATA_W-1:0] exp_beat_q[$];

    // Environment controls, written by the stimulus block.
    int          ready_mode = 0;   // 0: always ready, 1: every 4th cycle, 2: never
    logic [31:0] data_base  = '0;
    int          rsp_idx    = 0;   // grants issued in the current burst
    int          err_at     = -1;
    bit          rsp_hold   = 1'b0;
    bit          chk_done_en = 1'b1;
    int          beats_rem  = 0;
    int          beat_cnt   = 0;
    int          done_cnt   = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_beat(input logic [31:0] base, input int b);
        logic [DATA_W-1:0] v = '0;
        for (int w = 0; w < WPB; w++) begin
            v[w*MEM_W +: MEM_W] = base + 32'(b*WPB + w);
        end
        return v;
    endfunction

    // ---------------- memory responder and ready driver ----------------
    initial begin : env
        bit          pend = 1'b0;
        logic [31:0] pdata = '0;
        bit          perr = 1'b0;
        int          cyc = 0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        dma_ready_i  = 1'b1;
`ifdef DMA_READ_ENGINE_ERR_EN
        mem_rerr_i   = 1'b0;
`endif
        forever begin
            @(negedge clk);
            cyc++;
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
`ifdef DMA_READ_ENGINE_ERR_EN
            mem_rerr_i   = 1'b0;
`endif
            dma_ready_i  = (ready_mode == 0) ? 1'b1 :
                           (ready_mode == 1) ? ((cyc % 4) == 0) : 1'b0;
            if (!rst) begin
                if (pend) begin
                    if (!rsp_hold) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = pdata;
`ifdef DMA_READ_ENGINE_ERR_EN
                        mem_rerr_i   = perr;
`endif
                        pend = 1'b0;
                    end
                end else if (mem_req_o) begin
                    mem_gnt_i = 1'b1;
                    chk("req_expected", DATA_W'(exp_addr_q.size() != 0), DATA_W'(1));
                    if (exp_addr_q.size() != 0)
                        chk("mem_addr", DATA_W'(mem_addr_o), DATA_W'(exp_addr_q.pop_front()));
                    pdata = data_base + 32'(rsp_idx);
                    perr  = (rsp_idx == err_at);
                    rsp_idx++;
                    pend = 1'b1;
                end
            end
        end
    end

    // ---------------- output stream monitor ----------------
    initial begin : mon
        bit prev_final = 1'b0;
        bit prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev_final = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_final)
                    chk("done_busy_after_last", DATA_W'({dma_done_o, dma_busy_o}), DATA_W'(2'b10));
                else if (chk_done_en)
                    chk("no_spurious_done", DATA_W'(dma_done_o), DATA_W'(0));
                if (dma_done_o) done_cnt++;
                if (prev_stall) chk("valid_held", DATA_W'(dma_valid_o), DATA_W'(1));
                prev_final = 1'b0;
                if (dma_valid_o) begin
                    chk("beat_expected", DATA_W'(exp_beat_q.size() != 0), DATA_W'(1));
                    if (exp_beat_q.size() != 0) begin
                        chk("beat_data", dma_data_o, exp_beat_q[0]);
                        if (dma_ready_i) begin
                            void'(exp_beat_q.pop_front());
                            beat_cnt++;
                            beats_rem--;
                            prev_final = (beats_rem == 0);
                        end
                    end
                end
                prev_stall = dma_valid_o & ~dma_ready_i;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic start_burst(input logic [31:0] addr, input logic [3:0] len,
                               input logic [31:0] base, input int err_word);
        logic [31:0] a = addr & ~32'h1F;
        data_base = base;
        rsp_idx   = 0;
        err_at    = err_word;
        beats_rem = (err_word >= 0) ? 0 : int'(len) + 1;
        for (int b = 0; b <= int'(len); b++) begin
            if (err_word < 0) exp_beat_q.push_back(mk_beat(base, b));
            for (int w = 0; w < WPB; w++) begin
                if (err_word < 0 || (b == 0 && w <= err_word)) exp_addr_q.push_back(a);
                a += 32'd4;
            end
        end
        dma_start_i     = 1'b1;
        dma_addr_i      = addr;
        dma_burst_len_i = len;
        tick();
        dma_start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (dma_done_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done"}, DATA_W'(dma_done_o), DATA_W'(1));
    endtask

    initial begin : stim
        int n;
        int d0;
        int b0;
        tick();
        chk("rst_ctrl", DATA_W'({dma_valid_o, dma_busy_o, dma_done_o, mem_req_o, mem_addr_o}), '0);
        chk("rst_data", dma_data_o, '0);
        rst = 1'b0;
        tick();

        // Single beat at 0x100, word data = word index.
        start_burst(32'h100, 4'd0, 32'h0, -1);
        chk("s1_busy_req", DATA_W'({dma_busy_o, mem_req_o}), DATA_W'(2'b11));
        chk("s1_first_addr", DATA_W'(mem_addr_o), DATA_W'(32'h100));
        wait_done("s1", 400);
        chk("s1_beat_literal", mk_beat(32'h0, 0),
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        // Start in the done cycle must be ignored.
        dma_start_i = 1'b1;
        dma_addr_i  = 32'h200;
        tick();
        dma_start_i = 1'b0;
        repeat (4) tick();
        chk("s1_start_in_done_ignored", DATA_W'({dma_busy_o, mem_req_o}), '0);

        // Two beats with ready only every 4th cycle.
        ready_mode = 1;
        b0 = beat_cnt;
        start_burst(32'h400, 4'd1, 32'h100, -1);
        wait_done("s2", 600);
        chk("s2_beats", DATA_W'(beat_cnt - b0), DATA_W'(2));
        ready_mode = 0;
        tick();

        // Three beats with ready held low: both registers fill and reads stop.
        ready_mode = 2;
        start_burst(32'h800, 4'd2, 32'h200, -1);
        repeat (100) tick();
        chk("s3_grants_when_full", DATA_W'(rsp_idx), DATA_W'(16));
        chk("s3_no_req_when_full", DATA_W'({mem_req_o, dma_valid_o, dma_busy_o}), DATA_W'(3'b011));
        ready_mode = 0;
        wait_done("s3", 600);
        tick();

        // Start pulse during busy is ignored; unaligned start aligns down.
        start_burst(32'h100, 4'd0, 32'h300, -1);
        repeat (3) tick();
        dma_start_i = 1'b1;
        dma_addr_i  = 32'h200;
        tick();
        dma_start_i = 1'b0;
        wait_done("s4", 400);
        tick();
        start_burst(32'h31F, 4'd0, 32'h400, -1);
        wait_done("s4_align", 400);
        tick();

        // Reset after the third grant, with a response still outstanding.
        start_burst(32'h100, 4'd1, 32'h500, -1);
        n = 0;
        while (rsp_idx < 3 && n < 200) begin
            tick();
            n++;
        end
        chk("s5_third_grant", DATA_W'(rsp_idx), DATA_W'(3));
        rsp_hold = 1'b1;
        tick();
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        chk("s5_rst_ctrl", DATA_W'({dma_valid_o, dma_busy_o, dma_done_o, mem_req_o, mem_addr_o}), '0);
        chk("s5_rst_data", dma_data_o, '0);
        tick();
        tick();
        rst = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        beats_rem = 0;
        rsp_hold  = 1'b0;
        repeat (6) tick();
        chk("s5_after_abort", DATA_W'({dma_busy_o, dma_valid_o, mem_req_o}), '0);
        chk("s5_no_done", DATA_W'(done_cnt - d0), '0);
        start_burst(32'h340, 4'd0, 32'h600, -1);
        wait_done("s5_next", 400);
        tick();

        // Address wrap across the top of the address space.
        start_burst(32'hFFFF_FFE0, 4'd1, 32'h700, -1);
        wait_done("s6", 600);
        tick();

`ifdef DMA_READ_ENGINE_ERR_EN
        // Error response on word 5 of beat 0.
        chk_done_en = 1'b0;
        b0 = beat_cnt;
        start_burst(32'h900, 4'd0, 32'h800, 5);
        wait_done("s7", 400);
        tick();
        chk("s7_err_set", DATA_W'(dma_err_o), DATA_W'(1));
        repeat (4) tick();
        chk("s7_idle", DATA_W'({dma_busy_o, mem_req_o, dma_valid_o, dma_err_o}), DATA_W'(4'b0001));
        chk("s7_no_beat", DATA_W'(beat_cnt - b0), '0);
        chk_done_en = 1'b1;
        start_burst(32'h100, 4'd0, 32'h900, -1);
        chk("s7_err_cleared", DATA_W'(dma_err_o), '0);
        wait_done("s7_next", 400);
        tick();
`endif

        chk("addr_queue_drained", DATA_W'(exp_addr_q.size()), '0);
        chk("beat_queue_drained", DATA_W'(exp_beat_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_dma_read_engine
`default_nettype wire

// File: doc/dma_read_engine.md
DMA_READ_ENGINE -- requirements
Module: dma_read_engine

Interface
REQ-001 Parameter ADDR_W, default 32: byte-address width of request and memory ports.
REQ-002 Parameter DATA_W, default 256: width of one stream beat.
REQ-003 Parameter MEM_W, default 32: memory read-data width; DATA_W/MEM_W (default 8) is WORDS_PER_BEAT.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dma_start  input  1  single-cycle burst request from the accelerator control block.
REQ-007 dma_addr  input  ADDR_W  burst byte start address, sampled with dma_start.
REQ-008 dma_burst_len  input  4  beats minus one (0 means 1 beat, 15 means 16 beats), sampled with dma_start.
REQ-009 dma_valid  output  1  stream beat available.
REQ-010 dma_ready  input  1  consumer accepts beat.
REQ-011 dma_data  output  DATA_W  stream beat; word 0 in bits [MEM_W-1:0].
REQ-012 dma_busy  output  1  burst in progress.
REQ-013 dma_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-014 mem_req / mem_addr / mem_gnt  output 1 / output ADDR_W / input 1  memory read-request handshake.
REQ-015 mem_rvalid / mem_rdata  input 1 / input MEM_W  read response, exactly one per granted request, in order.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DRAIN.
REQ-017 IDLE: dma_start=1 latches address (bits [log2(DATA_W/8)-1:0] forced to 0), beat count and word count; enters REQ next cycle; dma_busy=1 from that cycle.
REQ-018 dma_start while dma_busy=1 is ignored, with no effect on state.
REQ-019 REQ: mem_req=1 and mem_addr stable until mem_gnt=1; then WAIT, with address += MEM_W/8.
REQ-020 One outstanding request at most; WAIT holds until mem_rvalid=1 and stores mem_rdata into the gather register at word index.
REQ-021 When the gather register is full it moves to the output register if that register is empty or is being accepted in the same cycle; otherwise the FSM holds in WAIT and issues no new request until it moves.
REQ-022 After the last word of the last beat is received, the FSM enters DRAIN; otherwise it returns to REQ.
REQ-023 dma_valid=1 while the output register is full; dma_data is stable while dma_valid=1 and dma_ready=0; a beat transfers when dma_valid and dma_ready are both 1.
REQ-024 DRAIN: when the final beat is accepted, dma_done pulses for one cycle, dma_busy=0 in the same cycle, and the FSM returns to IDLE.
REQ-025 dma_start in the dma_done cycle is ignored; a new burst is accepted from the next cycle onward.
REQ-026 Address arithmetic wraps modulo 2^ADDR_W, with no error.
REQ-027 mem_rvalid outside WAIT is ignored.

Reset
REQ-028 rst=1 forces the FSM to IDLE and clears counters, the gather register and the output register at once.
REQ-029 During rst all outputs are 0: dma_valid, dma_data, dma_busy, dma_done, mem_req and mem_addr.
REQ-030 rst mid-burst aborts the burst without a dma_done pulse; pending responses arriving after rst deasserts are discarded.

Configuration
REQ-031 Macro DMA_READ_ENGINE_ERR_EN defined: adds input mem_rerr (1, qualified by mem_rvalid) and output dma_err (1, sticky until next accepted dma_start).
REQ-032 With the macro defined, an error response discards the current gather and any remaining words, pulses dma_done, sets dma_err and returns to IDLE; a beat already in the output register is still presented.
REQ-033 Macro undefined: no mem_rerr or dma_err ports; every response is treated as valid data.

Structure
REQ-034 Shared package dma_pkg holds DMA_DATA_W, DMA_MEM_W, WORDS_PER_BEAT and the FSM state typedef, for use by the engine and the control block.
REQ-035 Sub-module dma_beat_packer implements the gather and output registers and stream handshake; the FSM and address counter stay in dma_read_engine.

Verification
REQ-036 Scenario: addr=0x100, burst_len=0, mem_rdata=word index 0..7, dma_ready=1, 1-cycle gnt/rvalid -> 8 requests at 0x100..0x11C; one beat 0x00000007_..._00000000; dma_done one cycle after acceptance.
REQ-037 Scenario: burst_len=1, dma_ready=1 only every 4th cycle -> exactly 2 beats; dma_data stable while stalled; mem_req stops while both registers are full.
REQ-038 Scenario: dma_start pulses during busy at addr=0x200 -> ignored; only the original 0x100 burst runs.
REQ-039 Scenario: rst asserted after the 3rd mem_gnt -> all outputs 0 in the same cycle; no dma_done; a later rvalid is discarded; next burst is correct.
REQ-040 Scenario: addr=0xFFFFFFE0, burst_len=1 -> second beat's addresses wrap to 0x00000000..0x0000001C.
REQ-041 Scenario (DMA_READ_ENGINE_ERR_EN): mem_rerr on word 5 of beat 0 -> no beat emitted; dma_done pulses; dma_err=1 until the next dma_start.
